store_checker: RTL and testbench
================================

# store_checker

Synthesisable, parametrised store checker that watches the processor data-memory write port (`memwrite`, `dataaddr`, `writedata`) and decides pass or fail on-chip. It is the generalised successor of the single-store "address 84 / data 7" check. It supports a list of `N_EXP` expected stores, ordered or unordered matching, and a cycle timeout. It sits beside `top`, taps the same three signals the bench observes, and drives status for either the bench or a board LED/UART path.

## Interface
- `WIDTH`, 32: width of address and data.
- `N_EXP`, 4: number of expected stores (≥1).
- `TIMEOUT`, 1000: cycles in RUN before a timeout failure (≥1).
- `ORDERED`, 1: 1 = expected stores must occur in list order; 0 = any order.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state and enters RUN.
- `restart` in 1: synchronous; same effect as reset on the next edge.
- `memwrite` in 1: store strobe, sampled on the rising edge.
- `dataaddr` in WIDTH: store address.
- `writedata` in WIDTH: store data.
- `exp_addr` in N_EXP*WIDTH: expected addresses; entry i is `[i*WIDTH +: WIDTH]`. Static while running.
- `exp_data` in N_EXP*WIDTH: expected data, same packing as `exp_addr`.
- `done` out 1: in PASS or FAIL.
- `pass` out 1: in PASS.
- `fail_cause` out 2: 0 none, 1 data mismatch, 2 timeout.
- `fail_addr` out WIDTH: `dataaddr` of the offending store; 0 on timeout.
- `fail_data` out WIDTH: `writedata` of the offending store; 0 on timeout.
- `matched` out clog2(N_EXP+1): number of expected stores satisfied.
- `cycles` out clog2(TIMEOUT+1): cycles spent in RUN; saturates.

## Operation
- States are RUN, PASS and FAIL. Reset or `restart` leads to RUN with all counters and the hit bitmap cleared.
- Reset values: `done`=0, `pass`=0, `fail_cause`=0, `fail_addr`=0, `fail_data`=0, `matched`=0, `cycles`=0.
- In RUN, `cycles` increments every edge.
- Stores with `memwrite`=0 are ignored. X/Z on inputs is outside scope.
- Ordered mode (`ORDERED`=1), with pointer `idx`=`matched`:
  - Address and data equal to entry `idx`: `idx`+1.
  - Address equal to entry `idx` but data different: go to FAIL with cause 1.
  - Any other store is ignored, including stores that match later entries.
- Unordered mode (`ORDERED`=0), using a hit bitmap:
  - A store matching an unhit entry on both address and data sets that entry's bit. If several unhit entries match, only the lowest index is set.
  - If the address equals at least one unhit entry and the data matches none of them: go to FAIL with cause 1.
  - Stores that touch only already-hit entries are ignored.
  - `matched` is the popcount of the bitmap, kept as a registered counter.
- When `matched` reaches `N_EXP`: go to PASS.
- Timeout: if the edge in RUN would make `cycles` equal `TIMEOUT` and no PASS occurs on that edge: go to FAIL with cause 2.
- Simultaneous events: store evaluation takes priority over timeout on the same edge. A completing store gives PASS; a mismatching store gives cause 1.
- PASS and FAIL are terminal. All outputs hold and later stores are ignored until `reset` or `restart`.
- `restart` takes priority over any store on the same edge.

## Timing
- Every output is registered.
- The status of a store sampled at edge k is visible after edge k. `done`/`pass` rise in the same cycle that `matched` reaches `N_EXP`.
- Throughput is one store per cycle, with no back-pressure on the processor.
- Asynchronous reset mid-run clears everything immediately. Deassertion is synchronised externally.
- `cycles` counts edges since leaving reset. Timeout fires at the edge where `cycles` transitions `TIMEOUT-1`→`TIMEOUT`.

## Structure
- Shared package `store_check_pkg` holds:
  - state encoding `ST_RUN`=2'd0, `ST_PASS`=2'd1, `ST_FAIL`=2'd2;
  - `FC_NONE`, `FC_MISMATCH`, `FC_TIMEOUT`.
- One sub-module, `store_match_vec`: combinational per-entry compare. It takes the store, the expected arrays and the hit mask, and returns `addr_hit[N_EXP]` and `full_hit[N_EXP]`.
- The top of this block holds the FSM, the counters, the bitmap and the lowest-index priority encoder.

## Test plan
- `N_EXP`=1, entry {84, 7}; store (80,3) then (84,7) → `pass`=1, `matched`=1, `fail_cause`=0 after the second edge.
- Ordered, entries {{84,7},{88,9}}; store (88,9) then (84,7) then (88,9) → first store ignored, then PASS on the third.
- Ordered, entry0 {84,7}; store (84,6) → FAIL, `fail_cause`=1, `fail_addr`=84, `fail_data`=6; a later (84,7) has no effect.
- Unordered, entries {{84,7},{88,9},{84,7}}; stores (84,7), (84,7), (88,9) → bits 0, 2, 1 set in turn, PASS on the third store.
- `TIMEOUT`=5, no matching stores → FAIL with cause 2 and `cycles`=5. Repeat with the completing store on the 5th edge → PASS.
- Assert `reset` low mid-run with `matched`=1 → all outputs 0 immediately. After release, the same stimulus reproduces the original result. `restart` behaves the same synchronously.

Source files
------------

// File: rtl/store_check_pkg.sv
// Shared encodings for the on-chip store checker:
// FSM states and failure causes.
package store_check_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISMATCH = 2'd1,
        FC_TIMEOUT  = 2'd2
    } cause_t;

endpackage

// File: rtl/store_match_vec.sv
// Per-entry compare of one store against the expected list.
// Entries already marked in the mask never report a hit.
module store_match_vec
    import store_check_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_EXP = 4
) (
    input  logic [WIDTH-1:0]       dataaddr,
    input  logic [WIDTH-1:0]       writedata,
    input  logic [N_EXP*WIDTH-1:0] exp_addr,
    input  logic [N_EXP*WIDTH-1:0] exp_data,
    input  logic [N_EXP-1:0]       mask,
    output logic [N_EXP-1:0]       addr_hit,
    output logic [N_EXP-1:0]       full_hit
);

    always_comb begin
        addr_hit = '0;
        full_hit = '0;
        for (int i = 0; i < N_EXP; i++) begin
            addr_hit[i] = !mask[i]
                && (dataaddr == exp_addr[i*WIDTH +: WIDTH]);
            full_hit[i] = addr_hit[i]
                && (writedata == exp_data[i*WIDTH +: WIDTH]);
        end
    end

endmodule

// File: rtl/store_checker.sv
// Watches the data-memory write port and decides pass/fail
// against a list of expected stores, with a cycle timeout.
module store_checker
    import store_check_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N_EXP   = 4,
    parameter int TIMEOUT = 1000,
    parameter int ORDERED = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         restart,
    input  logic                         memwrite,
    input  logic [WIDTH-1:0]             dataaddr,
    input  logic [WIDTH-1:0]             writedata,
    input  logic [N_EXP*WIDTH-1:0]       exp_addr,
    input  logic [N_EXP*WIDTH-1:0]       exp_data,
    output logic                         done,
    output logic                         pass,
    output logic [1:0]                   fail_cause,
    output logic [WIDTH-1:0]             fail_addr,
    output logic [WIDTH-1:0]             fail_data,
    output logic [$clog2(N_EXP+1)-1:0]   matched,
    output logic [$clog2(TIMEOUT+1)-1:0] cycles
);

    localparam int MW = $clog2(N_EXP+1);
    localparam int CW = $clog2(TIMEOUT+1);

    state_t           state_q, state_n;
    cause_t           cause_q, cause_n;
    logic [WIDTH-1:0] fa_q, fa_n;
    logic [WIDTH-1:0] fd_q, fd_n;
    logic [N_EXP-1:0] hit_q, hit_n;
    logic [MW-1:0]    cnt_q, cnt_n;
    logic [CW-1:0]    cyc_q, cyc_n;

    logic [N_EXP-1:0] mask;
    logic [N_EXP-1:0] addr_hit;
    logic [N_EXP-1:0] full_hit;
    logic [N_EXP-1:0] sel;
    logic             mis;
    logic             found;

    // Ordered mode looks only at entry cnt_q, so no masking.
    assign mask = (ORDERED != 0) ? '0 : hit_q;

    store_match_vec #(
        .WIDTH (WIDTH),
        .N_EXP (N_EXP)
    ) u_match (
        .dataaddr  (dataaddr),
        .writedata (writedata),
        .exp_addr  (exp_addr),
        .exp_data  (exp_data),
        .mask      (mask),
        .addr_hit  (addr_hit),
        .full_hit  (full_hit)
    );

    always_comb begin
        sel   = '0;
        mis   = 1'b0;
        found = 1'b0;
        if (ORDERED != 0) begin
            for (int i = 0; i < N_EXP; i++) begin
                if (cnt_q == MW'(i)) begin
                    sel[i] = full_hit[i];
                    mis    = addr_hit[i] & ~full_hit[i];
                end
            end
        end else begin
            for (int i = 0; i < N_EXP; i++) begin
                if (full_hit[i] && !found) begin
                    sel[i] = 1'b1;
                    found  = 1'b1;
                end
            end
            mis = !found && (|addr_hit);
        end
    end

    always_comb begin
        state_n = state_q;
        cause_n = cause_q;
        fa_n    = fa_q;
        fd_n    = fd_q;
        hit_n   = hit_q;
        cnt_n   = cnt_q;
        cyc_n   = cyc_q;
        if (restart) begin
            state_n = ST_RUN;
            cause_n = FC_NONE;
            fa_n    = '0;
            fd_n    = '0;
            hit_n   = '0;
            cnt_n   = '0;
            cyc_n   = '0;
        end else if (state_q == ST_RUN) begin
            if (cyc_q != CW'(TIMEOUT))
                cyc_n = cyc_q + 1'b1;
            if (memwrite && mis) begin
                state_n = ST_FAIL;
                cause_n = FC_MISMATCH;
                fa_n    = dataaddr;
                fd_n    = writedata;
            end else begin
                if (memwrite && (|sel)) begin
                    hit_n = hit_q | sel;
                    cnt_n = cnt_q + 1'b1;
                end
                // A completing store wins over the timeout edge.
                if (cnt_n == MW'(N_EXP)) begin
                    state_n = ST_PASS;
                end else if (cyc_q == CW'(TIMEOUT-1)) begin
                    state_n = ST_FAIL;
                    cause_n = FC_TIMEOUT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cause_q <= FC_NONE;
            fa_q    <= '0;
            fd_q    <= '0;
            hit_q   <= '0;
            cnt_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_n;
            cause_q <= cause_n;
            fa_q    <= fa_n;
            fd_q    <= fd_n;
            hit_q   <= hit_n;
            cnt_q   <= cnt_n;
            cyc_q   <= cyc_n;
        end
    end

    assign done       = (state_q != ST_RUN);
    assign pass       = (state_q == ST_PASS);
    assign fail_cause = cause_q;
    assign fail_addr  = fa_q;
    assign fail_data  = fd_q;
    assign matched    = cnt_q;
    assign cycles     = cyc_q;

endmodule

// File: tb/tb_store_checker.sv
// Bench for store_checker: three configurations share one store
// stream and are checked against a list-level model each cycle.
module tb_store_checker;

    localparam logic [31:0] EA [3][3] = '{
        '{32'd84, 32'd0,  32'd0},
        '{32'd84, 32'd88, 32'd0},
        '{32'd84, 32'd88, 32'd84}};
    localparam logic [31:0] ED [3][3] = '{
        '{32'd7, 32'd0, 32'd0},
        '{32'd7, 32'd9, 32'd0},
        '{32'd7, 32'd9, 32'd7}};
    localparam int NK  [3] = '{1, 2, 3};
    localparam int ORD [3] = '{1, 1, 0};
    localparam int TMO [3] = '{5, 1000, 1000};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        restart;
    logic        memwrite;
    logic [31:0] dataaddr;
    logic [31:0] writedata;

    logic        dn [3];
    logic        ps [3];
    logic [1:0]  fc [3];
    logic [31:0] fa [3];
    logic [31:0] fd [3];
    logic [31:0] ma [3];
    logic [31:0] cy [3];

    logic [0:0] ma0;
    logic [2:0] cy0;
    logic [1:0] ma1, ma2;
    logic [9:0] cy1, cy2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    store_checker #(.WIDTH(32), .N_EXP(1), .TIMEOUT(5),
                    .ORDERED(1)) d0 (
        .clk(clk), .reset(reset), .restart(restart),
        .memwrite(memwrite), .dataaddr(dataaddr),
        .writedata(writedata),
        .exp_addr(EA[0][0]), .exp_data(ED[0][0]),
        .done(dn[0]), .pass(ps[0]), .fail_cause(fc[0]),
        .fail_addr(fa[0]), .fail_data(fd[0]),
        .matched(ma0), .cycles(cy0));

    store_checker #(.WIDTH(32), .N_EXP(2), .TIMEOUT(1000),
                    .ORDERED(1)) d1 (
        .clk(clk), .reset(reset), .restart(restart),
        .memwrite(memwrite), .dataaddr(dataaddr),
        .writedata(writedata),
        .exp_addr({EA[1][1], EA[1][0]}),
        .exp_data({ED[1][1], ED[1][0]}),
        .done(dn[1]), .pass(ps[1]), .fail_cause(fc[1]),
        .fail_addr(fa[1]), .fail_data(fd[1]),
        .matched(ma1), .cycles(cy1));

    store_checker #(.WIDTH(32), .N_EXP(3), .TIMEOUT(1000),
                    .ORDERED(0)) d2 (
        .clk(clk), .reset(reset), .restart(restart),
        .memwrite(memwrite), .dataaddr(dataaddr),
        .writedata(writedata),
        .exp_addr({EA[2][2], EA[2][1], EA[2][0]}),
        .exp_data({ED[2][2], ED[2][1], ED[2][0]}),
        .done(dn[2]), .pass(ps[2]), .fail_cause(fc[2]),
        .fail_addr(fa[2]), .fail_data(fd[2]),
        .matched(ma2), .cycles(cy2));

    assign ma[0] = 32'(ma0);
    assign ma[1] = 32'(ma1);
    assign ma[2] = 32'(ma2);
    assign cy[0] = 32'(cy0);
    assign cy[1] = 32'(cy1);
    assign cy[2] = 32'(cy2);

    typedef struct {
        int          st;
        int          cause;
        logic [31:0] fa;
        logic [31:0] fd;
        int          matched;
        int          cycles;
        bit [2:0]    hit;
    } mstate_t;

    mstate_t m [3];

    function automatic mstate_t mclr();
        mstate_t r;
        r.st = 0; r.cause = 0; r.fa = 0; r.fd = 0;
        r.matched = 0; r.cycles = 0; r.hit = '0;
        return r;
    endfunction

    function automatic mstate_t mnext(int k, mstate_t s, logic we,
                                      logic [31:0] a, logic [31:0] d);
        mstate_t r = s;
        int      j = -1;
        bit      any = 0;
        if (r.st != 0) return r;
        r.cycles++;
        if (we) begin
            if (ORD[k] != 0) begin
                if (a == EA[k][r.matched]) begin
                    if (d == ED[k][r.matched]) r.matched++;
                    else begin
                        r.st = 2; r.cause = 1; r.fa = a; r.fd = d;
                    end
                end
            end else begin
                for (int i = NK[k] - 1; i >= 0; i--) begin
                    if (!r.hit[i] && a == EA[k][i]) begin
                        any = 1;
                        if (d == ED[k][i]) j = i;
                    end
                end
                if (j >= 0) begin
                    r.hit[j] = 1'b1;
                    r.matched++;
                end else if (any) begin
                    r.st = 2; r.cause = 1; r.fa = a; r.fd = d;
                end
            end
        end
        if (r.st == 0) begin
            if (r.matched == NK[k]) r.st = 1;
            else if (r.cycles == TMO[k]) begin
                r.st = 2; r.cause = 2;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 3; k++)
            m[k] <= (!reset || restart) ? mclr()
                  : mnext(k, m[k], memwrite, dataaddr, writedata);
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("d%0d.done", k), 32'(dn[k]),
                    32'(m[k].st != 0));
                chk($sformatf("d%0d.pass", k), 32'(ps[k]),
                    32'(m[k].st == 1));
                chk($sformatf("d%0d.cause", k), 32'(fc[k]),
                    32'(m[k].cause));
                chk($sformatf("d%0d.faddr", k), fa[k], m[k].fa);
                chk($sformatf("d%0d.fdata", k), fd[k], m[k].fd);
                chk($sformatf("d%0d.matched", k), ma[k],
                    32'(m[k].matched));
                chk($sformatf("d%0d.cycles", k), cy[k],
                    32'(m[k].cycles));
            end
        end
    end

    task automatic st(logic we, logic [31:0] a, logic [31:0] d);
        memwrite  = we;
        dataaddr  = a;
        writedata = d;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) st(1'b0, 32'd0, 32'd0);
    endtask

    task automatic rst_sync();
        restart = 1'b1;
        idle(1);
        restart = 1'b0;
    endtask

    initial begin
        restart   = 1'b0;
        memwrite  = 1'b0;
        dataaddr  = '0;
        writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.done", 32'(dn[0]), 32'd0);
        chk("rst.cycles", cy[1], 32'd0);
        chk("rst.matched", ma[2], 32'd0);
        reset = 1'b1;

        st(1'b1, 32'd80, 32'd3);
        chk("t1.d0.pass0", 32'(ps[0]), 32'd0);
        st(1'b1, 32'd84, 32'd7);
        chk("t1.d0.pass", 32'(ps[0]), 32'd1);
        chk("t1.d0.matched", ma[0], 32'd1);
        chk("t1.d0.cause", 32'(fc[0]), 32'd0);
        chk("t1.d0.cycles", cy[0], 32'd2);

        rst_sync();
        st(1'b1, 32'd88, 32'd9);
        chk("t2.d1.matched0", ma[1], 32'd0);
        chk("t2.d1.done0", 32'(dn[1]), 32'd0);
        st(1'b1, 32'd84, 32'd7);
        chk("t2.d1.matched1", ma[1], 32'd1);
        st(1'b1, 32'd88, 32'd9);
        chk("t2.d1.pass", 32'(ps[1]), 32'd1);
        chk("t2.d1.matched2", ma[1], 32'd2);

        rst_sync();
        st(1'b1, 32'd84, 32'd6);
        chk("t3.d0.done", 32'(dn[0]), 32'd1);
        chk("t3.d0.pass", 32'(ps[0]), 32'd0);
        chk("t3.d0.cause", 32'(fc[0]), 32'd1);
        chk("t3.d0.faddr", fa[0], 32'd84);
        chk("t3.d0.fdata", fd[0], 32'd6);
        st(1'b1, 32'd84, 32'd7);
        chk("t3.d0.hold", 32'(fc[0]), 32'd1);
        chk("t3.d0.matched", ma[0], 32'd0);

        rst_sync();
        st(1'b1, 32'd84, 32'd7);
        chk("t4.d2.m1", ma[2], 32'd1);
        st(1'b1, 32'd84, 32'd7);
        chk("t4.d2.m2", ma[2], 32'd2);
        chk("t4.d2.done2", 32'(dn[2]), 32'd0);
        st(1'b1, 32'd88, 32'd9);
        chk("t4.d2.m3", ma[2], 32'd3);
        chk("t4.d2.pass", 32'(ps[2]), 32'd1);

        rst_sync();
        idle(4);
        chk("t5.d0.done4", 32'(dn[0]), 32'd0);
        chk("t5.d0.cyc4", cy[0], 32'd4);
        idle(1);
        chk("t5.d0.done5", 32'(dn[0]), 32'd1);
        chk("t5.d0.cause", 32'(fc[0]), 32'd2);
        chk("t5.d0.cyc5", cy[0], 32'd5);
        chk("t5.d0.faddr", fa[0], 32'd0);
        idle(3);
        chk("t5.d0.sat", cy[0], 32'd5);

        rst_sync();
        idle(4);
        st(1'b1, 32'd84, 32'd7);
        chk("t5b.d0.pass", 32'(ps[0]), 32'd1);
        chk("t5b.d0.cause", 32'(fc[0]), 32'd0);
        chk("t5b.d0.cyc", cy[0], 32'd5);

        rst_sync();
        st(1'b1, 32'd84, 32'd7);
        chk("t6.d1.m1", ma[1], 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t6.d1.matched", ma[1], 32'd0);
        chk("t6.d1.cycles", cy[1], 32'd0);
        chk("t6.d0.pass", 32'(ps[0]), 32'd0);
        chk("t6.d0.done", 32'(dn[0]), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        st(1'b1, 32'd84, 32'd7);
        st(1'b1, 32'd88, 32'd9);
        chk("t6.d1.pass", 32'(ps[1]), 32'd1);

        restart = 1'b1;
        st(1'b1, 32'd84, 32'd7);
        restart = 1'b0;
        chk("t7.d0.pass", 32'(ps[0]), 32'd0);
        chk("t7.d0.matched", ma[0], 32'd0);
        chk("t7.d1.done", 32'(dn[1]), 32'd0);
        st(1'b1, 32'd84, 32'd7);
        st(1'b1, 32'd88, 32'd9);
        chk("t7.d1.pass", 32'(ps[1]), 32'd1);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
